clock_rtc: RTL and testbench

Parametrised BCD real-time clock. It keeps seconds, minutes and hours internally and presents them in either 12-hour (with PM flag) or 24-hour format, selectable at run time. It supports synchronous time load with validity checking, a programmable prescaler from `ena` strobes to seconds, and an hour:minute alarm. It sits in the counter family as the successor to the fixed 12-hour clock and drives display and timer logic directly.

---
 rtl/clock_rtc_pkg.sv | 48 ++++
 rtl/clock_rtc_bcd_mod60.sv | 46 ++++
 rtl/clock_rtc.sv | 163 ++++++++++++++++
 tb/tb_clock_rtc.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_rtc_pkg.sv
// Shared constants, the BCD time bundle and the hour/BCD conversion helpers
// used by the real-time clock.
package clock_rtc_pkg;

    localparam logic [7:0] BCD_59   = 8'h59;
    localparam logic [4:0] H24_MAX  = 5'd23;
    localparam logic [4:0] H12_MAX  = 5'd12;
    localparam logic [6:0] MIN_MAX  = 7'd59;

    typedef struct packed {
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
    } bcd_time_t;

    function automatic logic [6:0] bcd_to_bin(input logic [7:0] v);
        return ({3'b000, v[7:4]} * 7'd10) + {3'b000, v[3:0]};
    endfunction

    // Both nibbles must be decimal digits and the value must not exceed max_bin.
    function automatic logic bcd_valid(input logic [7:0] v, input logic [6:0] max_bin);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (bcd_to_bin(v) <= max_bin);
    endfunction

    function automatic logic [4:0] h12_to_h24(input logic [7:0] hh_bcd, input logic pm_flag);
        logic [6:0] bin7;
        logic [4:0] bin;
        bin7 = bcd_to_bin(hh_bcd);
        bin  = bin7[4:0];
        if (bin == H12_MAX) begin
            return pm_flag ? H12_MAX : 5'd0;
        end
        return pm_flag ? (bin + H12_MAX) : bin;
    endfunction

    function automatic logic [7:0] h24_to_bcd(input logic [4:0] h);
        logic [4:0] ones;
        if (h >= 5'd20) begin
            ones = h - 5'd20;
            return {4'd2, ones[3:0]};
        end else if (h >= 5'd10) begin
            ones = h - 5'd10;
            return {4'd1, ones[3:0]};
        end
        return {4'd0, h[3:0]};
    endfunction

endpackage

// File: rtl/clock_rtc_bcd_mod60.sv
// BCD 00-59 counter with load priority over increment; carry marks the 59->00 wrap.
module bcd_mod60
    import clock_rtc_pkg::*;
(
    input  logic       clk,
    input  logic       srst,
    input  logic       inc,
    input  logic       ld,
    input  logic [7:0] ld_val,
    output logic [7:0] q,
    output logic [7:0] q_next,
    output logic       carry
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        carry = 1'b0;
        if (ld) begin
            cnt_d = ld_val;
        end else if (inc) begin
            if (cnt_q == BCD_59) begin
                cnt_d = 8'h00;
                carry = 1'b1;
            end else if (cnt_q[3:0] == 4'd9) begin
                cnt_d = {cnt_q[7:4] + 4'd1, 4'd0};
            end else begin
                cnt_d = {cnt_q[7:4], cnt_q[3:0] + 4'd1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= 8'h00;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q      = cnt_q;
    assign q_next = cnt_d;

endmodule

// File: rtl/clock_rtc.sv
// BCD real-time clock: prescaler, binary 24-hour counter, 12/24-hour view,
// validated time load and a daily hour:minute alarm.
module clock_rtc
    import clock_rtc_pkg::*;
#(
    parameter int TICK_DIV     = 1,
    parameter bit ALARM_EN_RST = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       mode24,
    input  logic       load,
    input  logic [7:0] load_hh,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
    input  logic       load_pm,
    input  logic       alarm_set,
    input  logic       alarm_clr,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       pm,
    output logic       sec_tick,
    output logic       alarm,
    output logic       load_err
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [4:0]    h24_q, h24_d;
    logic [4:0]    alarm_h_q, alarm_h_d;
    logic [7:0]    alarm_m_q, alarm_m_d;
    logic          armed_q, armed_d;
    logic          sec_tick_q, sec_tick_d;
    logic          alarm_q, alarm_d;
    logic          load_err_q, load_err_d;

    bcd_time_t     load_t;
    logic          hh_valid, hm_valid, load_valid, load_ok, alarm_ok, set_req;
    logic          advance, tick;
    logic [4:0]    load_h24, h12_bin;
    logic [7:0]    ss_next, mm_next;
    logic          ss_carry, mm_carry;

    assign load_t = '{hh: load_hh, mm: load_mm, ss: load_ss};

    // Hour range depends on the display format the load value is expressed in.
    always_comb begin
        if (mode24) begin
            hh_valid = bcd_valid(load_t.hh, 7'(H24_MAX));
            load_h24 = 5'(bcd_to_bin(load_t.hh));
        end else begin
            hh_valid = bcd_valid(load_t.hh, 7'(H12_MAX)) && (load_t.hh != 8'h00);
            load_h24 = h12_to_h24(load_t.hh, load_pm);
        end
    end

    assign hm_valid   = hh_valid && bcd_valid(load_t.mm, MIN_MAX);
    assign load_valid = hm_valid && bcd_valid(load_t.ss, MIN_MAX);
    assign load_ok    = load && load_valid;
    assign set_req    = alarm_set && !alarm_clr;
    assign alarm_ok   = set_req && hm_valid;

    assign advance = ena && (presc_q == PRESC_LAST);
    assign tick    = advance && !load_ok;

    bcd_mod60 u_ss (
        .clk    (clk),
        .srst   (reset),
        .inc    (tick),
        .ld     (load_ok),
        .ld_val (load_t.ss),
        .q      (ss),
        .q_next (ss_next),
        .carry  (ss_carry)
    );

    bcd_mod60 u_mm (
        .clk    (clk),
        .srst   (reset),
        .inc    (ss_carry),
        .ld     (load_ok),
        .ld_val (load_t.mm),
        .q      (mm),
        .q_next (mm_next),
        .carry  (mm_carry)
    );

    always_comb begin
        presc_d    = presc_q;
        h24_d      = h24_q;
        alarm_h_d  = alarm_h_q;
        alarm_m_d  = alarm_m_q;
        armed_d    = armed_q;
        sec_tick_d = tick;
        load_err_d = (load && !load_valid) || (set_req && !hm_valid);

        if (load_ok) begin
            presc_d = '0;
            h24_d   = load_h24;
        end else begin
            if (ena) begin
                presc_d = advance ? '0 : presc_q + PW'(1);
            end
            if (mm_carry) begin
                h24_d = (h24_q == H24_MAX) ? 5'd0 : h24_q + 5'd1;
            end
        end

        if (alarm_clr) begin
            armed_d = 1'b0;
        end else if (alarm_ok) begin
            armed_d   = 1'b1;
            alarm_h_d = load_h24;
            alarm_m_d = load_t.mm;
        end

        // Match against the time this advance creates, so alarm aligns with sec_tick.
        alarm_d = armed_q && tick && (ss_next == 8'h00) &&
                  (mm_next == alarm_m_q) && (h24_d == alarm_h_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q    <= '0;
            h24_q      <= 5'd0;
            alarm_h_q  <= 5'd0;
            alarm_m_q  <= 8'h00;
            armed_q    <= ALARM_EN_RST;
            sec_tick_q <= 1'b0;
            alarm_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            h24_q      <= h24_d;
            alarm_h_q  <= alarm_h_d;
            alarm_m_q  <= alarm_m_d;
            armed_q    <= armed_d;
            sec_tick_q <= sec_tick_d;
            alarm_q    <= alarm_d;
            load_err_q <= load_err_d;
        end
    end

    always_comb begin
        h12_bin = h24_q;
        if (h24_q == 5'd0) begin
            h12_bin = H12_MAX;
        end else if (h24_q > H12_MAX) begin
            h12_bin = h24_q - H12_MAX;
        end
        hh = mode24 ? h24_to_bcd(h24_q) : h24_to_bcd(h12_bin);
        pm = !mode24 && (h24_q >= H12_MAX);
    end

    assign sec_tick = sec_tick_q;
    assign alarm    = alarm_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_clock_rtc.sv
// Directed bench for clock_rtc with TICK_DIV=4; inputs change on the falling
// edge and outputs are checked on the following falling edge.
module tb_clock_rtc;

    logic       clk = 1'b0;
    logic       reset, ena, mode24, load, load_pm, alarm_set, alarm_clr;
    logic [7:0] load_hh, load_mm, load_ss;
    logic [7:0] hh, mm, ss;
    logic       pm, sec_tick, alarm, load_err;

    int checks   = 0;
    int failures = 0;

    clock_rtc #(.TICK_DIV(4), .ALARM_EN_RST(1'b0)) dut (
        .clk       (clk),
        .reset     (reset),
        .ena       (ena),
        .mode24    (mode24),
        .load      (load),
        .load_hh   (load_hh),
        .load_mm   (load_mm),
        .load_ss   (load_ss),
        .load_pm   (load_pm),
        .alarm_set (alarm_set),
        .alarm_clr (alarm_clr),
        .hh        (hh),
        .mm        (mm),
        .ss        (ss),
        .pm        (pm),
        .sec_tick  (sec_tick),
        .alarm     (alarm),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m,
                           input logic [7:0] s, input logic p);
        load = 1'b1; load_hh = h; load_mm = m; load_ss = s; load_pm = p;
        cycle();
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; mode24 = 1'b0;
        cycle(); cycle();
        reset = 1'b0;
        checks++;
        if ({hh, mm, ss, pm} !== {8'h12, 8'h00, 8'h00, 1'b0}) begin
            failures++;
            $display("FAIL reset_12h: got %h:%h:%h pm=%b, want 12:00:00 pm=0", hh, mm, ss, pm);
        end
        checks++;
        if ({sec_tick, alarm, load_err} !== 3'b000) begin
            failures++;
            $display("FAIL reset_pulses: got %b, want 000", {sec_tick, alarm, load_err});
        end
        mode24 = 1'b1; #1;
        checks++;
        if ({hh, pm} !== {8'h00, 1'b0}) begin
            failures++;
            $display("FAIL reset_24h: got hh=%h pm=%b, want hh=00 pm=0", hh, pm);
        end
        $display("test_reset done");
    endtask

    task automatic test_12h_rollover();
        mode24 = 1'b0;
        do_load(8'h11, 8'h59, 8'h59, 1'b0);
        checks++;
        if ({hh, mm, ss, pm} !== {8'h11, 8'h59, 8'h59, 1'b0}) begin
            failures++;
            $display("FAIL load_am: got %h:%h:%h pm=%b, want 11:59:59 pm=0", hh, mm, ss, pm);
        end
        ena = 1'b1;
        repeat (3) cycle();
        checks++;
        if (sec_tick !== 1'b0) begin
            failures++;
            $display("FAIL early_tick: got sec_tick=%b, want 0", sec_tick);
        end
        cycle();
        ena = 1'b0;
        checks++;
        if ({sec_tick, hh, mm, ss, pm} !== {1'b1, 8'h12, 8'h00, 8'h00, 1'b1}) begin
            failures++;
            $display("FAIL noon: got tick=%b %h:%h:%h pm=%b, want tick=1 12:00:00 pm=1",
                     sec_tick, hh, mm, ss, pm);
        end
        do_load(8'h11, 8'h59, 8'h59, 1'b1);
        ena = 1'b1;
        repeat (4) cycle();
        ena = 1'b0;
        checks++;
        if ({hh, mm, ss, pm} !== {8'h12, 8'h00, 8'h00, 1'b0}) begin
            failures++;
            $display("FAIL midnight: got %h:%h:%h pm=%b, want 12:00:00 pm=0", hh, mm, ss, pm);
        end
        mode24 = 1'b1; #1;
        checks++;
        if (hh !== 8'h00) begin
            failures++;
            $display("FAIL midnight_24h: got hh=%h, want 00", hh);
        end
        $display("test_12h_rollover done");
    endtask

    task automatic test_modes();
        mode24 = 1'b1;
        do_load(8'h13, 8'h45, 8'h00, 1'b0);
        checks++;
        if ({hh, pm} !== {8'h13, 1'b0}) begin
            failures++;
            $display("FAIL view24: got hh=%h pm=%b, want 13 0", hh, pm);
        end
        mode24 = 1'b0; #1;
        checks++;
        if ({hh, mm, pm} !== {8'h01, 8'h45, 1'b1}) begin
            failures++;
            $display("FAIL view12: got hh=%h mm=%h pm=%b, want 01 45 1", hh, mm, pm);
        end
        mode24 = 1'b1;
        $display("test_modes done");
    endtask

    task automatic test_prescaler();
        logic exp_tick;
        do_load(8'h10, 8'h00, 8'h00, 1'b0);
        ena = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            exp_tick = ((i % 4) == 3);
            checks++;
            if (sec_tick !== exp_tick) begin
                failures++;
                $display("FAIL presc_cycle%0d: got sec_tick=%b, want %b", i, sec_tick, exp_tick);
            end
        end
        checks++;
        if (ss !== 8'h03) begin
            failures++;
            $display("FAIL presc_ss: got ss=%h, want 03", ss);
        end
        // Two counted cycles, three idle, then two more: advance lands on index 6.
        for (int i = 0; i < 7; i++) begin
            ena = !(i >= 2 && i <= 4);
            cycle();
            exp_tick = (i == 6);
            checks++;
            if (sec_tick !== exp_tick) begin
                failures++;
                $display("FAIL gap_cycle%0d: got sec_tick=%b, want %b", i, sec_tick, exp_tick);
            end
        end
        ena = 1'b0;
        checks++;
        if (ss !== 8'h04) begin
            failures++;
            $display("FAIL gap_ss: got ss=%h, want 04", ss);
        end
        $display("test_prescaler done");
    endtask

    task automatic test_invalid_load();
        logic [7:0] bad_h [5] = '{8'h05, 8'h13, 8'h24, 8'h05, 8'h00};
        logic [7:0] bad_m [5] = '{8'h06, 8'h06, 8'h06, 8'h1A, 8'h06};
        logic [7:0] bad_s [5] = '{8'h60, 8'h07, 8'h07, 8'h07, 8'h07};
        logic       bad_f [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        mode24 = 1'b1;
        do_load(8'h05, 8'h06, 8'h07, 1'b0);
        for (int i = 0; i < 5; i++) begin
            mode24 = bad_f[i];
            do_load(bad_h[i], bad_m[i], bad_s[i], 1'b0);
            mode24 = 1'b1; #1;
            checks++;
            if ({load_err, hh, mm, ss} !== {1'b1, 8'h05, 8'h06, 8'h07}) begin
                failures++;
                $display("FAIL bad_load%0d: got err=%b %h:%h:%h, want err=1 05:06:07",
                         i, load_err, hh, mm, ss);
            end
            cycle();
            checks++;
            if (load_err !== 1'b0) begin
                failures++;
                $display("FAIL err_pulse%0d: got load_err=%b, want 0", i, load_err);
            end
        end
        do_load(8'h23, 8'h59, 8'h59, 1'b0);
        checks++;
        if ({load_err, hh, mm, ss} !== {1'b0, 8'h23, 8'h59, 8'h59}) begin
            failures++;
            $display("FAIL max_load: got err=%b %h:%h:%h, want err=0 23:59:59",
                     load_err, hh, mm, ss);
        end
        $display("test_invalid_load done");
    endtask

    task automatic test_alarm();
        mode24 = 1'b1;
        alarm_set = 1'b1; load_hh = 8'h07; load_mm = 8'h30; load_pm = 1'b0;
        cycle();
        alarm_set = 1'b0;
        checks++;
        if (load_err !== 1'b0) begin
            failures++;
            $display("FAIL alarm_set_err: got load_err=%b, want 0", load_err);
        end
        for (int pass = 0; pass < 2; pass++) begin
            do_load(8'h07, 8'h29, 8'h59, 1'b0);
            ena = 1'b1;
            repeat (3) cycle();
            checks++;
            if (alarm !== 1'b0) begin
                failures++;
                $display("FAIL alarm_early%0d: got alarm=%b, want 0", pass, alarm);
            end
            cycle();
            ena = 1'b0;
            checks++;
            if ({sec_tick, alarm, hh, mm, ss} !== {1'b1, (pass == 0), 8'h07, 8'h30, 8'h00}) begin
                failures++;
                $display("FAIL alarm_hit%0d: got tick=%b alarm=%b %h:%h:%h, want tick=1 alarm=%b 07:30:00",
                         pass, sec_tick, alarm, hh, mm, ss, (pass == 0));
            end
            cycle();
            checks++;
            if (alarm !== 1'b0) begin
                failures++;
                $display("FAIL alarm_len%0d: got alarm=%b, want 0", pass, alarm);
            end
            alarm_clr = 1'b1;
            cycle();
            alarm_clr = 1'b0;
        end
        $display("test_alarm done");
    endtask

    task automatic test_load_tick();
        mode24 = 1'b1;
        do_load(8'h10, 8'h20, 8'h30, 1'b0);
        ena = 1'b1;
        repeat (3) cycle();
        do_load(8'h01, 8'h02, 8'h03, 1'b0);
        ena = 1'b0;
        checks++;
        if ({sec_tick, hh, mm, ss} !== {1'b0, 8'h01, 8'h02, 8'h03}) begin
            failures++;
            $display("FAIL load_vs_tick: got tick=%b %h:%h:%h, want tick=0 01:02:03",
                     sec_tick, hh, mm, ss);
        end
        $display("test_load_tick done");
    endtask

    task automatic test_reset_load();
        mode24 = 1'b1;
        do_load(8'h04, 8'h05, 8'h06, 1'b0);
        reset = 1'b1;
        do_load(8'h09, 8'h09, 8'h09, 1'b0);
        reset = 1'b0;
        checks++;
        if ({hh, mm, ss, load_err} !== {8'h00, 8'h00, 8'h00, 1'b0}) begin
            failures++;
            $display("FAIL reset_vs_load: got %h:%h:%h err=%b, want 00:00:00 err=0",
                     hh, mm, ss, load_err);
        end
        $display("test_reset_load done");
    endtask

    initial begin
        reset = 1'b1; ena = 1'b0; mode24 = 1'b0; load = 1'b0; load_pm = 1'b0;
        alarm_set = 1'b0; alarm_clr = 1'b0;
        load_hh = 8'h00; load_mm = 8'h00; load_ss = 8'h00;
        test_reset();
        test_12h_rollover();
        test_modes();
        test_prescaler();
        test_invalid_load();
        test_alarm();
        test_load_tick();
        test_reset_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
